// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared constants and types for the bomb slot scheduler
package bomb_pkg;

  localparam int NUM_SLOTS   = 4;
  localparam int START_BOMBS = 2;
  localparam int MAX_BOMBS   = 3;
  localparam int TILE_SHIFT  = 5;

  typedef logic [5:0] tile_t;
  typedef logic       player_t;

  // Pixel coordinate of a player's top-left corner to its tile index.
  function automatic tile_t pos_to_tile(input logic [10:0] pos);
    return tile_t'(pos >> TILE_SHIFT);
  endfunction

endpackage

// File: rtl/bomb_slot_scheduler_if.sv
// rtl/bomb_slot_scheduler_if.sv - player-side and slot-side signal bundle of the scheduler
interface bomb_slot_scheduler_if;
  import bomb_pkg::*;

  logic [1:0]           drop_key;
  logic [10:0]          p0_topLeftX;
  logic [10:0]          p0_topLeftY;
  logic [10:0]          p1_topLeftX;
  logic [10:0]          p1_topLeftY;
  logic [NUM_SLOTS-1:0] slot_blast;
  logic [1:0]           inc_bomb;
  logic                 score_reset;

  logic [NUM_SLOTS-1:0] slot_drop;
  tile_t                drop_tileX;
  tile_t                drop_tileY;
  logic [NUM_SLOTS-1:0] slot_busy;
  logic [NUM_SLOTS-1:0] slot_owner;
  logic [1:0]           drop_denied;
  logic [3:0]           bombs_left0;
  logic [3:0]           bombs_left1;

  // Game side: keyboard, positions, bomb blocks, power-ups.
  modport master (
    output drop_key, p0_topLeftX, p0_topLeftY, p1_topLeftX, p1_topLeftY,
    output slot_blast, inc_bomb, score_reset,
    input  slot_drop, drop_tileX, drop_tileY, slot_busy, slot_owner,
    input  drop_denied, bombs_left0, bombs_left1
  );

  // Scheduler side.
  modport slave (
    input  drop_key, p0_topLeftX, p0_topLeftY, p1_topLeftX, p1_topLeftY,
    input  slot_blast, inc_bomb, score_reset,
    output slot_drop, drop_tileX, drop_tileY, slot_busy, slot_owner,
    output drop_denied, bombs_left0, bombs_left1
  );

endinterface

// File: rtl/bomb_inventory_counter.sv
// rtl/bomb_inventory_counter.sv - saturating per-player bombs-left counter
module bomb_inventory_counter
  import bomb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       dec_i,
  input  logic [2:0] credit_i,
  input  logic       inc_i,
  output logic [3:0] count_o
);

  localparam logic [4:0] MAX5   = 5'(MAX_BOMBS);
  localparam logic [3:0] START4 = 4'(START_BOMBS);

  logic [3:0] count_q, count_d;
  logic [4:0] sum;
  logic       dec_eff;

  // Net change in 5 bits so credits and power-ups cannot wrap before clamping.
  always_comb begin
    dec_eff = dec_i & (count_q != 4'd0);
    sum     = {1'b0, count_q} + {2'b00, credit_i} + {4'b0000, inc_i} - {4'b0000, dec_eff};
    count_d = count_q;
    if (clear_i) begin
      count_d = START4;
    end else if (sum > MAX5) begin
      count_d = MAX5[3:0];
    end else begin
      count_d = sum[3:0];
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= START4;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bomb_slot_scheduler.sv
// rtl/bomb_slot_scheduler.sv - shares bomb slots between two players with round-robin arbitration
module bomb_slot_scheduler
  import bomb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  bomb_slot_scheduler_if.slave bus
);

  logic [1:0]           key_q;
  logic [1:0]           pend_q;
  logic                 rr_q;
  logic [NUM_SLOTS-1:0] busy_q;
  logic [NUM_SLOTS-1:0] owner_q;
  tile_t                slot_tx_q [NUM_SLOTS];
  tile_t                slot_ty_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_drop_q;
  tile_t                drop_tx_q;
  tile_t                drop_ty_q;
  logic [1:0]           denied_q;

  tile_t                tile_x [2];
  tile_t                tile_y [2];
  logic [3:0]           bombs [2];
  logic [2:0]           credit [2];
  logic [1:0]           key_edge;
  logic [1:0]           clash;
  logic [1:0]           elig;
  logic [1:0]           grant;
  logic [1:0]           deny;
  player_t              gp;
  logic [NUM_SLOTS-1:0] free_vec;
  logic [NUM_SLOTS-1:0] grant_slot;
  logic [NUM_SLOTS-1:0] release_vec;

  assign tile_x[0] = pos_to_tile(bus.p0_topLeftX);
  assign tile_y[0] = pos_to_tile(bus.p0_topLeftY);
  assign tile_x[1] = pos_to_tile(bus.p1_topLeftX);
  assign tile_y[1] = pos_to_tile(bus.p1_topLeftY);

  assign key_edge    = bus.drop_key & ~key_q;
  assign free_vec    = ~busy_q;
  assign release_vec = bus.slot_blast & busy_q;
  assign gp          = grant[1];

  // Eligibility of each pending player against registered slot state.
  always_comb begin
    clash = 2'b00;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (busy_q[i] && slot_tx_q[i] == tile_x[p] && slot_ty_q[i] == tile_y[p]) begin
          clash[p] = 1'b1;
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      elig[p] = pend_q[p] && (bombs[p] != 4'd0) && (|free_vec) && !clash[p];
    end
  end

  // One grant per cycle; rr_q breaks a tie, ineligible requests are dropped.
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant        = 2'b00;
      grant[rr_q]  = 1'b1;
    end
    deny = pend_q & ~elig;
  end

  // Lowest-index free slot receives the granted bomb.
  always_comb begin
    grant_slot = '0;
    if (|grant) begin
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
        if (free_vec[i]) begin
          grant_slot    = '0;
          grant_slot[i] = 1'b1;
        end
      end
    end
  end

  // Count exploded bombs per owner to credit back to inventory.
  always_comb begin
    credit[0] = 3'd0;
    credit[1] = 3'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (release_vec[i]) begin
        credit[owner_q[i]] = credit[owner_q[i]] + 3'd1;
      end
    end
  end

  // Request, slot table and registered pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q       <= '0;
      pend_q      <= '0;
      rr_q        <= 1'b0;
      busy_q      <= '0;
      owner_q     <= '0;
      slot_drop_q <= '0;
      drop_tx_q   <= '0;
      drop_ty_q   <= '0;
      denied_q    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_tx_q[i] <= '0;
        slot_ty_q[i] <= '0;
      end
    end else if (bus.score_reset) begin
      key_q       <= '0;
      pend_q      <= '0;
      rr_q        <= 1'b0;
      busy_q      <= '0;
      owner_q     <= '0;
      slot_drop_q <= '0;
      drop_tx_q   <= '0;
      drop_ty_q   <= '0;
      denied_q    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_tx_q[i] <= '0;
        slot_ty_q[i] <= '0;
      end
    end else begin
      key_q       <= bus.drop_key;
      pend_q      <= (pend_q & ~(grant | deny)) | key_edge;
      busy_q      <= (busy_q & ~release_vec) | grant_slot;
      slot_drop_q <= grant_slot;
      denied_q    <= deny;
      if (|grant) begin
        rr_q      <= ~gp;
        drop_tx_q <= tile_x[gp];
        drop_ty_q <= tile_y[gp];
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (grant_slot[i]) begin
          owner_q[i]   <= gp;
          slot_tx_q[i] <= tile_x[gp];
          slot_ty_q[i] <= tile_y[gp];
        end
      end
    end
  end

  bomb_inventory_counter u_inv0 (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (bus.score_reset),
    .dec_i    (grant[0]),
    .credit_i (credit[0]),
    .inc_i    (bus.inc_bomb[0]),
    .count_o  (bombs[0])
  );

  bomb_inventory_counter u_inv1 (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (bus.score_reset),
    .dec_i    (grant[1]),
    .credit_i (credit[1]),
    .inc_i    (bus.inc_bomb[1]),
    .count_o  (bombs[1])
  );

  assign bus.slot_drop   = slot_drop_q;
  assign bus.drop_tileX  = drop_tx_q;
  assign bus.drop_tileY  = drop_ty_q;
  assign bus.slot_busy   = busy_q;
  assign bus.slot_owner  = owner_q;
  assign bus.drop_denied = denied_q;
  assign bus.bombs_left0 = bombs[0];
  assign bus.bombs_left1 = bombs[1];

endmodule

// File: tb/tb_bomb_slot_scheduler.sv
// tb/tb_bomb_slot_scheduler.sv - directed self-checking bench for bomb_slot_scheduler
module tb_bomb_slot_scheduler;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bomb_slot_scheduler_if bus();

  bomb_slot_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int x0, input int y0, input int x1, input int y1);
    bus.p0_topLeftX = 11'(x0);
    bus.p0_topLeftY = 11'(y0);
    bus.p1_topLeftX = 11'(x1);
    bus.p1_topLeftY = 11'(y1);
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.drop_key    = 2'b00;
    bus.slot_blast  = 4'b0000;
    bus.inc_bomb    = 2'b00;
    bus.score_reset = 1'b0;
    set_pos(0, 0, 64, 64);
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_drop",   bus.slot_drop, 4'b0000);
    check("rst_busy",   bus.slot_busy, 4'b0000);
    check("rst_owner",  bus.slot_owner, 4'b0000);
    check("rst_denied", bus.drop_denied, 2'b00);
    check("rst_tile",   {bus.drop_tileX, bus.drop_tileY}, 12'h000);
    check("rst_bombs0", bus.bombs_left0, 4'd2);
    check("rst_bombs1", bus.bombs_left1, 4'd2);

    // Single press held: one launch only.
    bus.drop_key = 2'b01;
    tick();
    check("p0_pend_no_drop", bus.slot_drop, 4'b0000);
    tick();
    check("p0_drop", bus.slot_drop, 4'b0001);
    check("p0_busy", bus.slot_busy, 4'b0001);
    check("p0_owner", bus.slot_owner, 4'b0000);
    check("p0_tile", {bus.drop_tileX, bus.drop_tileY}, 12'h000);
    check("p0_bombs", bus.bombs_left0, 4'd1);
    n = 0;
    for (int c = 0; c < 19; c++) begin
      tick();
      if (bus.slot_drop != 4'b0000) n++;
    end
    check("held_no_repeat", n, 0);
    check("held_bombs", bus.bombs_left0, 4'd1);
    bus.drop_key = 2'b00;
    tick();

    // Second drop on the same tile is refused.
    bus.drop_key = 2'b01;
    tick();
    tick();
    check("same_tile_denied", bus.drop_denied, 2'b01);
    check("same_tile_nodrop", bus.slot_drop, 4'b0000);
    check("same_tile_bombs", bus.bombs_left0, 4'd1);
    bus.drop_key = 2'b00;
    tick();
    check("denied_pulse_end", bus.drop_denied, 2'b00);

    // Inventory empty, credit from blasts, power-up saturation.
    set_pos(32, 0, 64, 64);
    bus.drop_key = 2'b01;
    tick();
    tick();
    check("p0_second_slot", bus.slot_drop, 4'b0010);
    check("p0_empty", bus.bombs_left0, 4'd0);
    bus.drop_key = 2'b00;
    set_pos(64, 0, 64, 64);
    tick();
    bus.drop_key = 2'b01;
    tick();
    tick();
    check("empty_denied", bus.drop_denied, 2'b01);
    check("empty_nodrop", bus.slot_drop, 4'b0000);
    bus.drop_key = 2'b00;
    tick();
    bus.slot_blast = 4'b1000;
    tick();
    check("idle_blast_ignored", bus.bombs_left0, 4'd0);
    bus.slot_blast = 4'b0001;
    tick();
    bus.slot_blast = 4'b0000;
    check("blast_credit", bus.bombs_left0, 4'd1);
    check("blast_frees", bus.slot_busy, 4'b0010);
    bus.inc_bomb = 2'b01;
    tick();
    check("inc_1", bus.bombs_left0, 4'd2);
    tick();
    check("inc_2", bus.bombs_left0, 4'd3);
    tick();
    check("inc_sat", bus.bombs_left0, 4'd3);
    bus.inc_bomb = 2'b00;
    check("p1_untouched", bus.bombs_left1, 4'd2);

    // Round restart.
    bus.score_reset = 1'b1;
    tick();
    bus.score_reset = 1'b0;
    check("sr_busy", bus.slot_busy, 4'b0000);
    check("sr_bombs0", bus.bombs_left0, 4'd2);

    // Simultaneous presses, round-robin order.
    set_pos(0, 0, 64, 64);
    bus.drop_key = 2'b11;
    tick();
    tick();
    check("rr_first", bus.slot_drop, 4'b0001);
    check("rr_first_tile", {bus.drop_tileX, bus.drop_tileY}, 12'h000);
    tick();
    check("rr_second", bus.slot_drop, 4'b0010);
    check("rr_second_owner", bus.slot_owner, 4'b0010);
    check("rr_second_tile", {bus.drop_tileX, bus.drop_tileY}, {6'd2, 6'd2});
    bus.drop_key = 2'b00;
    set_pos(32, 0, 96, 96);
    tick();
    bus.drop_key = 2'b11;
    tick();
    tick();
    check("rr_again_p0", bus.slot_drop, 4'b0100);
    check("rr_again_tile", {bus.drop_tileX, bus.drop_tileY}, {6'd1, 6'd0});
    tick();
    check("rr_again_p1", bus.slot_drop, 4'b1000);
    check("rr_owners", bus.slot_owner, 4'b1010);
    check("rr_bombs", {bus.bombs_left0, bus.bombs_left1}, 8'h00);
    bus.drop_key = 2'b00;
    tick();

    // Pool full, then a slot freed on the same edge as the key.
    bus.inc_bomb = 2'b01;
    tick();
    bus.inc_bomb = 2'b00;
    set_pos(128, 128, 96, 96);
    bus.drop_key = 2'b01;
    tick();
    tick();
    check("full_denied", bus.drop_denied, 2'b01);
    check("full_bombs", bus.bombs_left0, 4'd1);
    bus.drop_key = 2'b00;
    tick();
    bus.slot_blast = 4'b0100;
    bus.drop_key   = 2'b01;
    tick();
    bus.slot_blast = 4'b0000;
    check("free_busy", bus.slot_busy, 4'b1011);
    check("free_credit", bus.bombs_left0, 4'd2);
    tick();
    check("reuse_slot2", bus.slot_drop, 4'b0100);
    check("reuse_tile", {bus.drop_tileX, bus.drop_tileY}, {6'd4, 6'd4});
    check("reuse_bombs", bus.bombs_left0, 4'd1);
    bus.drop_key = 2'b00;
    tick();

    // Restart with three live bombs, late blast afterwards.
    bus.slot_blast = 4'b1000;
    tick();
    bus.slot_blast = 4'b0000;
    check("three_busy", bus.slot_busy, 4'b0111);
    check("p1_credit", bus.bombs_left1, 4'd1);
    bus.score_reset = 1'b1;
    tick();
    bus.score_reset = 1'b0;
    check("sr3_busy", bus.slot_busy, 4'b0000);
    check("sr3_bombs", {bus.bombs_left0, bus.bombs_left1}, 8'h22);
    bus.slot_blast = 4'b0111;
    tick();
    bus.slot_blast = 4'b0000;
    check("late_blast_bombs", {bus.bombs_left0, bus.bombs_left1}, 8'h22);
    check("late_blast_busy", bus.slot_busy, 4'b0000);

    // Asynchronous reset kills an in-flight launch pulse.
    bus.drop_key = 2'b01;
    tick();
    tick();
    check("pre_areset_drop", bus.slot_drop, 4'b0001);
    reset = 1'b1;
    #1;
    check("areset_drop", bus.slot_drop, 4'b0000);
    check("areset_busy", bus.slot_busy, 4'b0000);
    check("areset_bombs0", bus.bombs_left0, 4'd2);
    reset = 1'b0;
    bus.drop_key = 2'b00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
